regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter AW, default 3, register address width (8 entries).
REQ-003 Parameter DW, default 16, register data width.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NREQ  per-requester write request.
REQ-007 req_addr  in  NREQ*AW  packed target addresses; requester i at bits [i*AW +: AW].
REQ-008 req_data  in  NREQ*DW  packed write data; requester i at bits [i*DW +: DW].
REQ-009 req_ready  out  NREQ  one-hot-or-zero accept; handshake when valid and ready are both high.
REQ-010 clear_start  in  1  one-cycle pulse requesting zero-fill of all entries.
REQ-011 clear_busy  out  1  high while the zero-fill sequence runs.
REQ-012 clear_done  out  1  one-cycle pulse at end of zero-fill.
REQ-013 rf_write  out  1  registered write strobe to the register file.
REQ-014 rf_wr_addr  out  AW  registered write address.
REQ-015 rf_wr_data  out  DW  registered write data.
REQ-016 grant_id  out  clog2(NREQ)  registered index of requester owning the current rf_write.

Function
REQ-017 FSM states: IDLE (arbitrate requesters), CLEAR (zero-fill); no other states.
REQ-018 In IDLE, at most one req_ready bit is high per cycle, combinationally from req_valid and the round-robin pointer.
REQ-019 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a completed handshake.
REQ-020 Handshake on requester i in cycle N -> rf_write=1, rf_wr_addr/rf_wr_data = requester i's values, grant_id=i in cycle N+1; one-cycle latency, one write per cycle maximum.
REQ-021 No handshake in cycle N -> rf_write=0 in N+1; rf_wr_addr/rf_wr_data/grant_id hold previous values.
REQ-022 Continuous requests from all NREQ requesters are each granted exactly once every NREQ cycles (full throughput, no bubbles).
REQ-023 A requester dropping req_valid before handshake loses nothing; pointer unchanged.
REQ-024 clear_start in IDLE -> CLEAR next cycle; all req_ready low in the clear_start cycle and throughout CLEAR.
REQ-025 CLEAR issues rf_write=1, rf_wr_data=0, rf_wr_addr = 0,1,...,2^AW-1 on consecutive cycles; grant_id=0 during CLEAR.
REQ-026 clear_busy high from the cycle after clear_start through the last clear write; clear_done pulses in the cycle after the last clear write, with FSM back in IDLE that same cycle.
REQ-027 clear_start while in CLEAR is ignored; clear_start coinciding with req_valid: clear wins, no handshake that cycle.
REQ-028 A write registered in the cycle before clear_start still appears on rf_write unchanged; clear writes follow it.

Reset
REQ-029 reset -> FSM IDLE, last_grant=NREQ-1 (requester 0 first priority), rf_write=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, req_ready=0, clear_busy=0, clear_done=0.
REQ-030 reset asserted mid-CLEAR aborts the sequence; no clear_done pulse issued.

Configuration
REQ-031 Macro REGFILE_WR_ARBITER_CLEAR_EN defined: zero-fill sequencer present per REQ-024..REQ-028, REQ-030.
REQ-032 Macro undefined: CLEAR state absent, clear_start ignored, clear_busy and clear_done tied 0; ports retained.

Structure
REQ-033 Shared package holds state enum (IDLE, CLEAR), RF_DEPTH=8, RF_AW=3, RF_DW=16 constants.
REQ-034 One sub-module rr_arbiter (NREQ-wide round-robin grant from request vector and pointer, combinational); FSM and output registers in top.

Verification
REQ-035 Reset, single requester 2 writes addr 5 data 0xBEEF -> next cycle rf_write=1, rf_wr_addr=5, rf_wr_data=0xBEEF, grant_id=2.
REQ-036 All 4 requesters valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, rf_write high 8 consecutive cycles.
REQ-037 clear_start with requesters 1 and 3 valid -> no ready that cycle; rf_wr_addr 0..7 with data 0 over 8 cycles; clear_done one cycle later; requester 1 granted next.
REQ-038 reset after third clear write -> all outputs at reset values next cycle, no clear_done.
REQ-039 clear_start pulsed again mid-CLEAR -> exactly 8 clear writes, one clear_done.
REQ-040 Macro undefined build: clear_start with requester 0 valid -> requester 0 granted same cycle, clear_busy/clear_done stay 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The zero-fill sequencer is built only when REGFILE_WR_ARBITER_CLEAR_EN is defined.
package regfile_wr_arbiter_pkg;

  localparam int unsigned RF_DEPTH = 8;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned RF_DW    = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } arbState_e;

  // Index width for an n-entry one-hot vector, never zero.
  function automatic int unsigned idxWidth(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester/register-file bus of the write arbiter, including the zero-fill controls
// (functional only with REGFILE_WR_ARBITER_CLEAR_EN).
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
);
  localparam int unsigned IW = idxWidth(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clear_start;
  logic               clear_busy;
  logic               clear_done;
  logic               rf_write;
  logic [AW-1:0]      rf_wr_addr;
  logic [DW-1:0]      rf_wr_data;
  logic [IW-1:0]      grant_id;

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, clear_busy, clear_done, rf_write, rf_wr_addr, rf_wr_data, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, clear_busy, clear_done, rf_write, rf_wr_addr, rf_wr_data, grant_id
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin grant: searches from lastGrant+1 (mod NREQ) for the first
// active request.
module rr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   lastGrant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grantIdx,
  output logic            anyGrant
);

  logic [IW-1:0] idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    idx      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = IW'((32'(lastGrant) + off) % NREQ);
      if (!anyGrant && req[idx]) begin
        anyGrant    = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write arbiter in front of a register file, with an optional zero-fill
// sequencer enabled by REGFILE_WR_ARBITER_CLEAR_EN.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wr_arbiter_if.slave   bus
);

  localparam int unsigned IW = idxWidth(NREQ);

  logic [IW-1:0]   lastGrant;
  logic [IW-1:0]   grantIdx;
  logic [NREQ-1:0] grant;
  logic            anyGrant;
  logic            idle;
  logic            clearReq;
  logic            readyEn;
  logic            handshake;
  int unsigned     sel;

  logic            rfWrite;
  logic [AW-1:0]   rfWrAddr;
  logic [DW-1:0]   rfWrData;
  logic [IW-1:0]   grantIdQ;

  rr_arbiter #(
    .NREQ(NREQ)
  ) uArb (
    .req      (bus.req_valid),
    .lastGrant(lastGrant),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

`ifdef REGFILE_WR_ARBITER_CLEAR_EN
  arbState_e state;
  logic      clearBusy;
  logic      clearDone;

  assign idle           = (state == StIdle);
  assign clearReq       = idle & bus.clear_start;
  assign bus.clear_busy = clearBusy;
  assign bus.clear_done = clearDone;
`else
  logic unusedClearStart;

  assign unusedClearStart = bus.clear_start;
  assign idle             = 1'b1;
  assign clearReq         = 1'b0;
  assign bus.clear_busy   = 1'b0;
  assign bus.clear_done   = 1'b0;
`endif

  // A clear request pre-empts arbitration in the cycle it arrives.
  assign readyEn       = idle & ~clearReq & ~reset;
  assign bus.req_ready = readyEn ? grant : '0;
  assign handshake     = readyEn & anyGrant;
  assign sel           = 32'(grantIdx);

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= IW'(NREQ - 1);
      rfWrite   <= 1'b0;
      rfWrAddr  <= '0;
      rfWrData  <= '0;
      grantIdQ  <= '0;
`ifdef REGFILE_WR_ARBITER_CLEAR_EN
      state     <= StIdle;
      clearBusy <= 1'b0;
      clearDone <= 1'b0;
`endif
    end else begin
`ifdef REGFILE_WR_ARBITER_CLEAR_EN
      clearDone <= 1'b0;
      if (state == StClear) begin
        // rfWrAddr doubles as the fill counter while clearing.
        if (rfWrAddr == {AW{1'b1}}) begin
          state     <= StIdle;
          rfWrite   <= 1'b0;
          clearBusy <= 1'b0;
          clearDone <= 1'b1;
        end else begin
          rfWrite  <= 1'b1;
          rfWrAddr <= rfWrAddr + AW'(1);
        end
      end else if (clearReq) begin
        state     <= StClear;
        clearBusy <= 1'b1;
        rfWrite   <= 1'b1;
        rfWrAddr  <= '0;
        rfWrData  <= '0;
        grantIdQ  <= '0;
      end else
`endif
      if (handshake) begin
        rfWrite   <= 1'b1;
        rfWrAddr  <= bus.req_addr[sel*AW +: AW];
        rfWrData  <= bus.req_data[sel*DW +: DW];
        grantIdQ  <= grantIdx;
        lastGrant <= grantIdx;
      end else begin
        rfWrite   <= 1'b0;
      end
    end
  end

  assign bus.rf_write   = rfWrite;
  assign bus.rf_wr_addr = rfWrAddr;
  assign bus.rf_wr_data = rfWrData;
  assign bus.grant_id   = grantIdQ;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; zero-fill steps run only when
// REGFILE_WR_ARBITER_CLEAR_EN is defined, otherwise the clear-ignored steps run.
module tb_regfile_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 16;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [1:0] g);
    chk({tag, ".rf_write"}, 32'(bus.rf_write), 32'(w));
    chk({tag, ".rf_wr_addr"}, 32'(bus.rf_wr_addr), 32'(a));
    chk({tag, ".rf_wr_data"}, 32'(bus.rf_wr_data), 32'(d));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(g));
  endtask

  task automatic chkRst(input string tag);
    chkOut(tag, 1'b0, '0, '0, '0);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, ".clear_busy"}, 32'(bus.clear_busy), 32'h0);
    chk({tag, ".clear_done"}, 32'(bus.clear_done), 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic doReset();
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.clear_start = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] addrOf(input int i);
    return AW'(7 - i);
  endfunction

  function automatic logic [DW-1:0] dataOf(input int i);
    return DW'(16'hA000 + i * 16'h0111);
  endfunction

  initial begin
    int writes;
    int dones;

    // Reset with every requester asserting: ready must stay low.
    reset           = 1'b1;
    bus.clear_start = 1'b0;
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, addrOf(i), dataOf(i));
    cyc();
    cyc();
    chkRst("reset");

    // Single requester 2: addr 5, data BEEF.
    reset         = 1'b0;
    bus.req_valid = '0;
    cyc();
    setReq(2, 1'b1, 3'd5, 16'hBEEF);
    #1;
    chk("single.ready", 32'(bus.req_ready), 32'h4);
    cyc();
    chkOut("single", 1'b1, 3'd5, 16'hBEEF, 2'd2);
    setReq(2, 1'b0, 3'd5, 16'hBEEF);
    #1;
    chk("single.idle_ready", 32'(bus.req_ready), 32'h0);
    cyc();
    chkOut("single.hold", 1'b0, 3'd5, 16'hBEEF, 2'd2);

    // All four continuously valid: 0,1,2,3,0,1,2,3 with no bubbles.
    doReset();
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, addrOf(i), dataOf(i));
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr.ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      cyc();
      chkOut("rr", 1'b1, addrOf(c % 4), dataOf(c % 4), 2'(c % 4));
    end

    // Sparse requests after last grant 3; idle cycles must not move the pointer.
    bus.req_valid = 4'b1010;
    #1;
    chk("sparse.ready1", 32'(bus.req_ready), 32'h2);
    cyc();
    chkOut("sparse.g1", 1'b1, addrOf(1), dataOf(1), 2'd1);
    #1;
    chk("sparse.ready3", 32'(bus.req_ready), 32'h8);
    cyc();
    chkOut("sparse.g3", 1'b1, addrOf(3), dataOf(3), 2'd3);
    bus.req_valid = 4'b0000;
    cyc();
    chk("sparse.idle_wr", 32'(bus.rf_write), 32'h0);
    cyc();
    bus.req_valid = 4'b1011;
    #1;
    chk("sparse.ready0", 32'(bus.req_ready), 32'h1);
    cyc();
    chkOut("sparse.g0", 1'b1, addrOf(0), dataOf(0), 2'd0);

`ifdef REGFILE_WR_ARBITER_CLEAR_EN
    // Clear with requesters 1 and 3 pending.
    doReset();
    setReq(1, 1'b1, 3'd2, 16'h1111);
    setReq(3, 1'b1, 3'd6, 16'h3333);
    bus.clear_start = 1'b1;
    #1;
    chk("clr.start_ready", 32'(bus.req_ready), 32'h0);
    cyc();
    bus.clear_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chkOut("clr.fill", 1'b1, AW'(k), 16'h0, 2'd0);
      chk("clr.ready", 32'(bus.req_ready), 32'h0);
      chk("clr.busy", 32'(bus.clear_busy), 32'h1);
      chk("clr.done_early", 32'(bus.clear_done), 32'h0);
      cyc();
    end
    chk("clr.done", 32'(bus.clear_done), 32'h1);
    chk("clr.busy_end", 32'(bus.clear_busy), 32'h0);
    chk("clr.wr_end", 32'(bus.rf_write), 32'h0);
    chk("clr.ready_after", 32'(bus.req_ready), 32'h2);
    cyc();
    chkOut("clr.next", 1'b1, 3'd2, 16'h1111, 2'd1);
    chk("clr.done_pulse", 32'(bus.clear_done), 32'h0);

    // Reset after the third clear write aborts without clear_done.
    doReset();
    bus.clear_start = 1'b1;
    cyc();
    bus.clear_start = 1'b0;
    cyc();
    cyc();
    chk("abort.third", 32'(bus.rf_wr_addr), 32'h2);
    reset = 1'b1;
    cyc();
    chkRst("abort.reset");
    reset = 1'b0;
    cyc();
    chk("abort.no_done", 32'(bus.clear_done), 32'h0);
    chk("abort.no_busy", 32'(bus.clear_busy), 32'h0);
    chk("abort.no_wr", 32'(bus.rf_write), 32'h0);

    // Pending write survives clear_start; repeated clear_start mid-CLEAR is ignored.
    setReq(2, 1'b1, 3'd4, 16'h2222);
    #1;
    chk("reclr.ready", 32'(bus.req_ready), 32'h4);
    cyc();
    setReq(2, 1'b0, 3'd4, 16'h2222);
    bus.clear_start = 1'b1;
    #1;
    chkOut("reclr.prior", 1'b1, 3'd4, 16'h2222, 2'd2);
    cyc();
    writes = 0;
    dones  = 0;
    for (int c = 0; c < 12; c++) begin
      bus.clear_start = (c == 3);
      if (bus.rf_write) begin
        chk("reclr.addr", 32'(bus.rf_wr_addr), 32'(writes));
        writes++;
      end
      if (bus.clear_done) dones++;
      cyc();
    end
    bus.clear_start = 1'b0;
    chk("reclr.writes", 32'(writes), 32'd8);
    chk("reclr.dones", 32'(dones), 32'd1);
`else
    // Without the sequencer clear_start is ignored and arbitration proceeds.
    doReset();
    setReq(0, 1'b1, 3'd3, 16'h5A5A);
    bus.clear_start = 1'b1;
    #1;
    chk("noclr.ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.clear_start = 1'b0;
    bus.req_valid   = '0;
    chkOut("noclr.grant", 1'b1, 3'd3, 16'h5A5A, 2'd0);
    chk("noclr.busy", 32'(bus.clear_busy), 32'h0);
    chk("noclr.done", 32'(bus.clear_done), 32'h0);
    cyc();
    chk("noclr.busy2", 32'(bus.clear_busy), 32'h0);
    chk("noclr.done2", 32'(bus.clear_done), 32'h0);
    chk("noclr.wr2", 32'(bus.rf_write), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
